// File: rtl/fixed_bytes_receiver.sv
// rtl/fixed_bytes_receiver.sv - collects L bytes of a stream into one wide word
// The completing byte is never stored; it is taken live from data into result[B-1:0].
module fixed_bytes_receiver #(
    parameter int L = 3,
    parameter int B = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           load,
    input  logic [B-1:0]   data,
    output logic           resolve,
    output logic [L*B-1:0] result
);

    localparam int CW = (L > 1) ? $clog2(L) : 1;

    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = load & ~start & ~reset;

    generate
        if (L == 1) begin : g_single
            assign cnt     = '0;
            assign resolve = accept;
            assign result  = data;
        end else begin : g_multi
            localparam logic [CW-1:0] LAST = CW'(L - 1);

            logic [B-1:0] byte_buf [L-1];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    cnt <= '0;
                    for (int i = 0; i < L - 1; i++) begin
                        byte_buf[i] <= '0;
                    end
                end else if (start) begin
                    cnt <= '0;
                end else if (load) begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                    end else begin
                        // Decoded write keeps the select within the buffer's own index range
                        for (int i = 0; i < L - 1; i++) begin
                            if (cnt == CW'(i)) begin
                                byte_buf[i] <= data;
                            end
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            assign resolve = accept & (cnt == LAST);

            always_comb begin
                result = '0;
                for (int i = 0; i < L - 1; i++) begin
                    result[(L-1-i)*B +: B] = byte_buf[i];
                end
                result[B-1:0] = data;
            end
        end
    endgenerate

endmodule

// File: tb/tb_fixed_bytes_receiver.sv
// tb/tb_fixed_bytes_receiver.sv - self-checking bench for fixed_bytes_receiver (L=3 and L=1)
module tb_fixed_bytes_receiver;

    localparam int L = 3;
    localparam int B = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          load  = 1'b0;
    logic [B-1:0]  data  = '0;
    logic          resolve3;
    logic [L*B-1:0] result3;
    logic          resolve1;
    logic [B-1:0]  result1;

    int tests = 0;
    int fails = 0;
    int pulses3 = 0;
    int pulses1 = 0;

    logic [B-1:0]   q[$];
    logic [L*B-1:0] exp_log[$];

    fixed_bytes_receiver #(.L(L), .B(B)) dut3 (
        .clock(clock), .reset(reset), .start(start), .load(load),
        .data(data), .resolve(resolve3), .result(result3)
    );

    fixed_bytes_receiver #(.L(1), .B(B)) dut1 (
        .clock(clock), .reset(reset), .start(start), .load(load),
        .data(data), .resolve(resolve1), .result(result1)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bytes of the open group are kept in a queue; the L-th accepted byte closes it.
    always @(negedge clock) begin
        logic            acc;
        logic            exp_res3;
        logic [L*B-1:0]  word;
        acc      = load && !start && !reset;
        exp_res3 = acc && (q.size() == L - 1);
        word = '0;
        foreach (q[i]) word = (word << B) | (L*B)'(q[i]);
        word = (word << B) | (L*B)'(data);

        check("resolve3", 64'(resolve3), 64'(exp_res3));
        if (exp_res3) check("result3", 64'(result3), 64'(word));
        check("resolve1", 64'(resolve1), 64'(acc));
        if (acc) check("result1", 64'(result1), 64'(data));

        if (resolve3) pulses3++;
        if (resolve1) pulses1++;

        if (reset || start) begin
            q.delete();
        end else if (load) begin
            if (exp_res3) begin
                q.delete();
                exp_log.push_back(word);
            end else begin
                q.push_back(data);
            end
        end
    end

    task automatic drive(input logic st, input logic ld, input logic [B-1:0] d);
        start = st;
        load  = ld;
        data  = d;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_counts();
        pulses3 = 0;
        pulses1 = 0;
    endtask

    initial begin
        logic [B-1:0] hello [6];
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h3F};

        reset = 1'b1;
        #2;
        check("reset_cnt", 64'(dut3.cnt), 64'd0);
        check("reset_resolve", 64'(resolve3), 64'd0);
        check("reset_result", 64'(result3), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(0, 0, 8'h00);

        // Hello test
        clear_counts();
        drive(1, 0, 8'h00);
        drive(1, 0, 8'h00);
        for (int i = 0; i < 6; i++) drive(0, 1, hello[i]);
        drive(0, 0, 8'h00);
        check("hello_pulses", 64'(pulses3), 64'd2);
        check("hello_pulses_l1", 64'(pulses1), 64'd6);
        check("hello_grp1", 64'(exp_log[exp_log.size()-2]), 64'h48656C);
        check("hello_grp2", 64'(exp_log[exp_log.size()-1]), 64'h6C6F3F);

        // start mid-group, start+load discards "n", gapped loads
        clear_counts();
        drive(0, 1, 8'h4F);
        drive(1, 1, 8'h6E);
        drive(0, 1, 8'h65);
        drive(0, 0, 8'h00);
        drive(0, 1, 8'h67);
        drive(0, 0, 8'h00);
        drive(0, 1, 8'h61);
        drive(0, 0, 8'h00);
        check("start_pulses", 64'(pulses3), 64'd1);
        check("start_grp", 64'(exp_log[exp_log.size()-1]), 64'h656761);

        // Five-cycle gap before the third byte
        clear_counts();
        drive(0, 1, 8'h78);
        drive(0, 1, 8'h79);
        for (int i = 0; i < 5; i++) drive(0, 0, 8'hAA);
        check("gap_no_pulse", 64'(pulses3), 64'd0);
        drive(0, 1, 8'h7A);
        drive(0, 0, 8'h00);
        check("gap_pulses", 64'(pulses3), 64'd1);
        check("gap_grp", 64'(exp_log[exp_log.size()-1]), 64'h78797A);

        // Asynchronous reset mid-group
        clear_counts();
        drive(0, 1, 8'h41);
        drive(0, 1, 8'h42);
        load = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_cnt", 64'(dut3.cnt), 64'd0);
        load = 1'b1;
        data = 8'h5A;
        #1;
        check("reset_forces_low", 64'(resolve3), 64'd0);
        @(negedge clock);
        #2;
        reset = 1'b0;
        load  = 1'b0;
        @(posedge clock);
        #1;
        drive(0, 1, 8'h43);
        drive(0, 1, 8'h44);
        drive(0, 1, 8'h45);
        drive(0, 0, 8'h00);
        check("reset_pulses", 64'(pulses3), 64'd1);
        check("reset_grp", 64'(exp_log[exp_log.size()-1]), 64'h434445);

        // Nine back-to-back bytes
        clear_counts();
        for (int i = 1; i <= 9; i++) drive(0, 1, B'(i));
        drive(0, 0, 8'h00);
        check("b2b_pulses", 64'(pulses3), 64'd3);
        check("b2b_pulses_l1", 64'(pulses1), 64'd9);
        check("b2b_grp1", 64'(exp_log[exp_log.size()-3]), 64'h010203);
        check("b2b_grp2", 64'(exp_log[exp_log.size()-2]), 64'h040506);
        check("b2b_grp3", 64'(exp_log[exp_log.size()-1]), 64'h070809);

        drive(0, 0, 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
